jt51_slot_seq: RTL and testbench
================================

# jt51_slot_seq

Parametrised slot sequencer and write scheduler for the JT51 operator pipeline. It runs the time-multiplexed slot counter and holds CPU register writes until their target slot comes around. It then emits one update strobe per pipeline stage offset, so each register field is written at the stage where its data is consumed. It sits between the register-address decoder and the per-channel/per-operator register files, and supports configurable channel/operator counts, pipeline depth and write buffering.

## Interface
- CH_W, 3, channel index width; channels = 2^CH_W
- OP_W, 2, operator index width; slots = 2^(CH_W+OP_W)
- STAGES, 7, number of pipeline stage offsets (stage k targets slot req+k)
- DW, 8, write data width
- rst  in  1  asynchronous reset, active-high
- clk  in  1  single clock; all state on its rising edge
- cen  in  1  slot-advance enable (P1)
- wr_valid  in  1  write request
- wr_ready  out  1  buffer can accept a request this cycle
- wr_op  in  OP_W  target operator
- wr_ch  in  CH_W  target channel
- wr_mask  in  STAGES  stage strobes required by the field
- wr_din  in  DW  write data
- upd  out  STAGES  per-stage update strobe (combinational from state and cur)
- upd_din  out  DW  data of the entry being issued
- cur  out  OP_W+CH_W  current slot {op,ch}
- cur_op  out  OP_W  cur upper bits
- cur_ch  out  CH_W  cur lower bits
- zero  out  1  registered; high during slot 0
- half  out  1  registered; high when cur[CH_W+OP_W-2:0]==0
- busy  out  1  any entry pending

## Operation
- Slot counter: cur <= cur+1 on each cen, with modulo-slots wrap. zero <= (next==0). half <= low bits of next == 0.
- Request req = {wr_op,wr_ch}. Stage-k slot = (req+k) mod slots. Wrap-around is natural; no special case.
- Head entry FSM: IDLE -> WAIT on accept. WAIT -> RUN (cnt=1) on the cen where cur==req. In RUN, cnt increments on each cen. RUN -> IDLE (retire) on the cen where cnt==STAGES-1.
- upd[0] = WAIT & cur==req & wr_mask_q[0]. upd[k] = RUN & cnt==k & wr_mask_q[k]. At most one bit is high per cycle.
- Strobes are qualified by the consumer with cen. upd and upd_din are stable for the whole cen period.
- An entry with a zero mask still walks the full sequence and emits no strobes. This keeps write ordering.
- Accept condition: wr_valid & wr_ready on any clk edge, independent of cen. wr_ready = !full.
- Acceptance in a cycle where cur==req with cen high does not arm. Arming waits for the next revolution.
- Entries issue strictly in acceptance order.

## Timing
- Reset: cur=0, zero=0, half=0, state IDLE, buffer empty, wr_ready=1, busy=0, upd=0, upd_din=0.
- Reset mid-operation discards all pending entries. No strobe is emitted after rst rises.
- Worst-case latency from accept to retire: slots + STAGES - 1 cen periods.
- Minimum latency: STAGES cen periods, when the request arrives just before cur==req.
- Simultaneous retire and accept: a retire on the same edge frees the slot. In single-entry mode wr_ready is still low that cycle (registered full), so the accept does not happen.
- busy = state!=IDLE | buffered entries.

## Configuration
- JT51_SLOT_SEQ_FIFO2_EN defined: 2-entry buffer. The second entry waits behind the head and becomes head on the retire edge. It arms only on a later cur==req match. wr_ready = fewer than 2 entries.
- Undefined: single entry. wr_ready = state==IDLE.

## Structure
- Shared package jt51_pkg holds the slot-width helper constants (SLOT_W = CH_W+OP_W) and the FSM state enum {IDLE, WAIT, RUN}.
- One natural sub-module, jt51_slot_cnt: the counter with its zero/half flags. This keeps the scheduler FSM separate from slot timing.

## Test plan
- Reset release, cen always 1 -> cur 0,1,…,31,0. zero high only while cur==0; half high at cur 0 and 16.
- Write op=1,ch=2 (req=10), mask=7'b1000011, accepted at cur=3 -> upd[0] at cur=10, upd[1] at cur=11, upd[6] at cur=16, none else. busy drops after the cur=16 cen.
- Write req=30, mask=all ones -> strobes at cur 30,31,0,1,2,3,4 (wrap). upd_din matches the written data throughout.
- Request accepted while cur==req with cen high -> no strobe this revolution; upd[0] fires 32 cens later.
- Back-to-back writes A(req 5) and B(req 2): without FIFO2, B is stalled (wr_ready=0) until A retires. With FIFO2, B is accepted, issues after A, and its strobes start at cur=2 of the following revolution.
- rst asserted while in RUN with cnt=3 -> upd=0 immediately. After release: busy=0, wr_ready=1, cur=0, and no stale strobes.

Source files
------------

// File: rtl/jt51_pkg.sv
// Shared definitions for the JT51 slot sequencer: default geometry,
// the slot-width helper and the head-entry scheduler state encoding.
package jt51_pkg;

   // Default geometry: 8 channels x 4 operators = 32 slots, 7 stage offsets.
   localparam int CH_W_DEF   = 3;
   localparam int OP_W_DEF   = 2;
   localparam int STAGES_DEF = 7;
   localparam int DW_DEF     = 8;

   // Head-entry scheduler states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } slot_state_t;

   // Slot index width: SLOT_W = CH_W + OP_W.
   function automatic int slot_w(input int ch_w, input int op_w);
      return ch_w + op_w;
   endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// Time-multiplexed slot counter. Advances on cen and wraps modulo 2^SLOT_W.
// zero/half are registered alongside the counter, so they describe the
// slot currently held in cur.
module jt51_slot_cnt #(
   parameter int SLOT_W = 5
) (
   input  logic              rst,
   input  logic              clk,
   input  logic              cen,
   output logic [SLOT_W-1:0] cur,
   output logic              zero,
   output logic              half
);

   logic [SLOT_W-1:0] nxt;

   // Next slot value, natural wrap at 2^SLOT_W.
   always_comb begin
      nxt = cur + {{(SLOT_W-1){1'b0}}, 1'b1};
   end

   // Slot register plus its flags, all advanced together on cen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur  <= '0;
         zero <= 1'b0;
         half <= 1'b0;
      end else if (cen) begin
         cur  <= nxt;
         zero <= (nxt == '0);
         half <= (nxt[SLOT_W-2:0] == '0);
      end
   end

endmodule

// File: rtl/jt51_slot_seq.sv
// JT51 slot sequencer and write scheduler.
// Holds CPU register writes until their target slot {op,ch} comes around,
// then emits one update strobe per stage offset (stage k at slot req+k).
// Optional build macro: JT51_SLOT_SEQ_FIFO2_EN selects a 2-entry write
// buffer; undefined gives a single entry.
//
// Write handshake: a request transfers on any rising clk edge where
// wr_valid and wr_ready are both high, regardless of cen. wr_ready depends
// only on registered state, never on wr_valid. The requester keeps wr_op,
// wr_ch, wr_mask and wr_din stable while wr_valid is high and unaccepted.
module jt51_slot_seq
   import jt51_pkg::*;
#(
   parameter int CH_W   = CH_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int STAGES = STAGES_DEF,
   parameter int DW     = DW_DEF
) (
   input  logic                 rst,
   input  logic                 clk,
   input  logic                 cen,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [OP_W-1:0]      wr_op,
   input  logic [CH_W-1:0]      wr_ch,
   input  logic [STAGES-1:0]    wr_mask,
   input  logic [DW-1:0]        wr_din,
   output logic [STAGES-1:0]    upd,
   output logic [DW-1:0]        upd_din,
   output logic [OP_W+CH_W-1:0] cur,
   output logic [OP_W-1:0]      cur_op,
   output logic [CH_W-1:0]      cur_ch,
   output logic                 zero,
   output logic                 half,
   output logic                 busy,
   output slot_state_t          dbg_state
);

   localparam int SLOT_W = slot_w(CH_W, OP_W);
   localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES-1);

   // Head entry: the one walking (or waiting to walk) its stage sequence.
   slot_state_t         state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [SLOT_W-1:0]   req_q, req_d;
   logic [STAGES-1:0]   mask_q, mask_d;
   logic [DW-1:0]       din_q, din_d;

   logic [SLOT_W-1:0]   wr_req;
   logic                slot_hit;
   logic                accept;
   logic                retire;
   logic                head_free;

   jt51_slot_cnt #(
      .SLOT_W (SLOT_W)
   ) u_cnt (
      .rst  (rst),
      .clk  (clk),
      .cen  (cen),
      .cur  (cur),
      .zero (zero),
      .half (half)
   );

   assign cur_op    = cur[SLOT_W-1:CH_W];
   assign cur_ch    = cur[CH_W-1:0];
   assign wr_req    = {wr_op, wr_ch};
   assign slot_hit  = (cur == req_q);
   assign accept    = wr_valid & wr_ready;
   assign upd_din   = din_q;
   assign dbg_state = state;

   // The head retires on the cen of its last stage; with a single stage
   // that is the arming cen itself.
   assign retire = cen & (((state == RUN) & (cnt == CNT_LAST)) |
                          ((state == WAIT) & slot_hit & (STAGES == 1)));
   assign head_free = (state == IDLE) | retire;

`ifdef JT51_SLOT_SEQ_FIFO2_EN
   // Second entry queued behind the head; promoted on the head's retire edge.
   logic                nxt_v, nxt_v_d;
   logic [SLOT_W-1:0]   nxt_req, nxt_req_d;
   logic [STAGES-1:0]   nxt_mask, nxt_mask_d;
   logic [DW-1:0]       nxt_din, nxt_din_d;

   assign wr_ready = !((state != IDLE) & nxt_v);
   assign busy     = (state != IDLE) | nxt_v;
`else
   assign wr_ready = (state == IDLE);
   assign busy     = (state != IDLE);
`endif

   // Next-state logic: head walk, retire, refill from buffer or new request.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      req_d   = req_q;
      mask_d  = mask_q;
      din_d   = din_q;
`ifdef JT51_SLOT_SEQ_FIFO2_EN
      nxt_v_d    = nxt_v;
      nxt_req_d  = nxt_req;
      nxt_mask_d = nxt_mask;
      nxt_din_d  = nxt_din;
`endif
      unique case (state)
         IDLE: ;
         WAIT: begin
            // Arming only happens from WAIT, so an entry accepted on the
            // very edge its slot goes by waits a full revolution.
            if (cen && slot_hit) begin
               state_d = RUN;
               cnt_d   = CNT_ONE;
            end
         end
         RUN: begin
            if (cen) cnt_d = cnt + CNT_ONE;
         end
         default: state_d = IDLE;
      endcase

      if (retire) begin
         state_d = IDLE;
         cnt_d   = '0;
      end

`ifdef JT51_SLOT_SEQ_FIFO2_EN
      if (head_free && nxt_v) begin
         state_d = WAIT;
         req_d   = nxt_req;
         mask_d  = nxt_mask;
         din_d   = nxt_din;
         nxt_v_d = 1'b0;
      end
      if (accept) begin
         if (head_free && !nxt_v) begin
            state_d = WAIT;
            req_d   = wr_req;
            mask_d  = wr_mask;
            din_d   = wr_din;
         end else begin
            nxt_v_d    = 1'b1;
            nxt_req_d  = wr_req;
            nxt_mask_d = wr_mask;
            nxt_din_d  = wr_din;
         end
      end
`else
      // wr_ready is only high in IDLE, so an accepted request always
      // lands directly in the head.
      if (accept && head_free) begin
         state_d = WAIT;
         req_d   = wr_req;
         mask_d  = wr_mask;
         din_d   = wr_din;
      end
`endif
   end

   // Scheduler state register; reset drops every pending entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         req_q  <= '0;
         mask_q <= '0;
         din_q  <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         req_q  <= req_d;
         mask_q <= mask_d;
         din_q  <= din_d;
      end
   end

`ifdef JT51_SLOT_SEQ_FIFO2_EN
   // Second-entry buffer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nxt_v    <= 1'b0;
         nxt_req  <= '0;
         nxt_mask <= '0;
         nxt_din  <= '0;
      end else begin
         nxt_v    <= nxt_v_d;
         nxt_req  <= nxt_req_d;
         nxt_mask <= nxt_mask_d;
         nxt_din  <= nxt_din_d;
      end
   end
`endif

   // Stage strobes: stage 0 on the arming slot, stage k while cnt==k.
   // Held for the whole cen period; the consumer qualifies with cen.
   always_comb begin
      upd = '0;
      if (state == WAIT && slot_hit) upd[0] = mask_q[0];
      if (state == RUN) begin
         for (int k = 1; k < STAGES; k++) begin
            if (cnt == CNT_W'(k)) upd[k] = mask_q[k];
         end
      end
   end

endmodule

// File: tb/tb_jt51_slot_seq.sv
// Directed bench for jt51_slot_seq (default geometry: 32 slots, 7 stages).
module tb_jt51_slot_seq;
   import jt51_pkg::*;

   localparam int CH_W = 3;
   localparam int OP_W = 2;
   localparam int STAGES = 7;
   localparam int DW = 8;
   localparam int SW = 5;
   localparam int EW = SW + 3 + DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cen = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [OP_W-1:0]   wr_op = '0;
   logic [CH_W-1:0]   wr_ch = '0;
   logic [STAGES-1:0] wr_mask = '0;
   logic [DW-1:0]     wr_din = '0;
   logic [STAGES-1:0] upd;
   logic [DW-1:0]     upd_din;
   logic [SW-1:0]     cur;
   logic [OP_W-1:0]   cur_op;
   logic [CH_W-1:0]   cur_ch;
   logic              zero, half, busy;
   slot_state_t       dbg_state;

   jt51_slot_seq #(
      .CH_W(CH_W), .OP_W(OP_W), .STAGES(STAGES), .DW(DW)
   ) dut (
      .rst(rst), .clk(clk), .cen(cen),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_op(wr_op), .wr_ch(wr_ch), .wr_mask(wr_mask), .wr_din(wr_din),
      .upd(upd), .upd_din(upd_din),
      .cur(cur), .cur_op(cur_op), .cur_ch(cur_ch),
      .zero(zero), .half(half), .busy(busy), .dbg_state(dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_checks = 0;
   int n_fail = 0;
   // Scoreboard entry: {slot[4:0], stage[2:0], din[7:0]}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference slot counter: zero/half registered with the incoming slot.
   logic [SW-1:0] cur_m;
   logic zero_m, half_m;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_m  <= '0;
         zero_m <= 1'b0;
         half_m <= 1'b0;
      end else if (cen) begin
         cur_m  <= cur_m + 5'd1;
         zero_m <= (cur_m == 5'd31);
         half_m <= (cur_m[3:0] == 4'hf);
      end
   end

   // Monitor: counter flags every cycle; strobes popped against the scoreboard.
   always @(negedge clk) begin
      check("cur", cur, cur_m);
      check("cur_op", cur_op, cur_m[4:3]);
      check("cur_ch", cur_ch, cur_m[2:0]);
      check("zero", zero, zero_m);
      check("half", half, half_m);
      if (rst) begin
         check("upd_in_reset", upd, 0);
      end else if (cen && upd != '0) begin
         if (exp_q.size() == 0) begin
            fail_now($sformatf("unexpected_strobe upd=%b cur=%0d", upd, cur));
         end else begin
            e = exp_q.pop_front();
            check("upd_bit", upd, 32'(1) << e[10:8]);
            check("strobe_slot", cur, e[15:11]);
            check("upd_din", upd_din, e[7:0]);
         end
      end
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cur(input logic [SW-1:0] v);
      int n = 0;
      while (cur !== v && n < 80) begin
         step();
         n++;
      end
      if (cur !== v) fail_now($sformatf("wait_cur_%0d timeout", v));
   endtask

   task automatic do_write(input logic [OP_W-1:0] op, input logic [CH_W-1:0] ch,
                           input logic [STAGES-1:0] mask, input logic [DW-1:0] din,
                           output logic [SW-1:0] acc);
      int n = 0;
      logic [SW-1:0] req;
      wr_op = op; wr_ch = ch; wr_mask = mask; wr_din = din;
      wr_valid = 1'b1;
      while (!wr_ready && n < 200) begin
         step();
         n++;
      end
      if (!wr_ready) begin
         fail_now("write_accept_timeout");
         wr_valid = 1'b0;
         acc = '1;
         return;
      end
      acc = cur;
      req = {op, ch};
      for (int k = 0; k < STAGES; k++)
         if (mask[k]) exp_q.push_back({5'(req + 5'(k)), 3'(k), din});
      step();
      wr_valid = 1'b0;
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      if (busy) fail_now("busy_timeout");
   endtask

   logic [SW-1:0] acc, acc_b;
   int len;

   initial begin
      // Reset state
      #1;
      check("rst_cur", cur, 0);
      check("rst_zero", zero, 0);
      check("rst_half", half, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_upd", upd, 0);
      check("rst_upd_din", upd_din, 0);
      check("rst_state", dbg_state, IDLE);
      repeat (3) step();
      rst = 1'b0;
      cen = 1'b1;
      repeat (5) step();
      // cen low: counter must hold
      cen = 1'b0;
      repeat (4) step();
      check("cen_hold_cur", cur, 5);
      cen = 1'b1;

      // req=10 accepted at cur=3: strobes at 10,11,16; busy for cur 4..16
      wait_cur(5'd3);
      do_write(2'd1, 3'd2, 7'b1000011, 8'h3C, acc);
      check("t2_acc_cur", acc, 3);
      busy_len(len);
      check("t2_busy_cycles", len, 13);

      // req=30, all stages: wraps 30,31,0..4
      do_write(2'd3, 3'd6, 7'h7f, 8'hA5, acc);
      busy_len(len);
      check("t3_latency_bound", (len <= 38), 1);

      // Accepted while cur==req: arms one revolution later
      wait_cur(5'd7);
      do_write(2'd0, 3'd7, 7'b0000001, 8'h77, acc);
      check("t4_acc_cur", acc, 7);
      check("t4_busy_now", busy, 1);
      check("t4_no_strobe_now", upd, 0);
      busy_len(len);
      check("t4_busy_cycles", len, 38);

      // Zero mask still walks the full sequence
      wait_cur(5'd0);
      do_write(2'd0, 3'd4, 7'b0000000, 8'hEE, acc);
      busy_len(len);
      check("t5_zero_mask_cycles", len, 10);

      // Back-to-back A(req 5) then B(req 2)
      wait_cur(5'd20);
      do_write(2'd0, 3'd5, 7'b0000001, 8'h11, acc);
      do_write(2'd0, 3'd2, 7'b0000101, 8'h22, acc_b);
      busy_len(len);
`ifdef JT51_SLOT_SEQ_FIFO2_EN
      check("t6_b_acc_cur", acc_b, 21);
      check("t6_busy_cycles", len, 51);
`else
      check("t6_b_acc_cur", acc_b, 12);
      check("t6_busy_cycles", len, 28);
`endif

      // Reset while RUN with cnt=3
      wait_cur(5'd28);
      do_write(2'd0, 3'd0, 7'h7f, 8'h5A, acc);
      wait_cur(5'd3);
      check("t7_state_run", dbg_state, RUN);
      check("t7_upd_cnt3", upd, 7'h08);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t7_upd_on_rst", upd, 0);
      check("t7_upd_din_on_rst", upd_din, 0);
      check("t7_busy_on_rst", busy, 0);
      repeat (2) step();
      rst = 1'b0;
      check("t7_busy_after", busy, 0);
      check("t7_wr_ready_after", wr_ready, 1);
      check("t7_cur_after", cur, 0);
      repeat (40) step();

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
